// File: rtl/apb_master_arb.sv
// apb_master_arb: round-robin arbiter sharing one APB3 master port among NREQ requesters
module apb_master_arb #(
   parameter int DWIDTH  = 32,
   parameter int AWIDTH  = 10,
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NREQ-1:0]          req_valid_i,
   input  logic [NREQ-1:0]          req_write_i,
   input  logic [NREQ*AWIDTH-1:0]   req_addr_i,
   input  logic [NREQ*DWIDTH-1:0]   req_wdata_i,
   output logic [NREQ-1:0]          req_ready_o,
   output logic [NREQ-1:0]          rsp_valid_o,
   output logic [DWIDTH-1:0]        rsp_rdata_o,
   output logic                     rsp_err_o,
   output logic                     busy_o,
   output logic                     psel_o,
   output logic                     penable_o,
   output logic                     pwrite_o,
   output logic [AWIDTH-1:0]        paddr_o,
   output logic [DWIDTH-1:0]        pwdata_o,
   input  logic [DWIDTH-1:0]        prdata_i,
   input  logic                     pready_i,
   input  logic                     pslverr_i
);
   localparam int LW = NREQ > 1 ? $clog2(NREQ) : 1;
   localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
   typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_e;
   state_e              state_q, state_d;
   logic [LW-1:0]       last_q, last_d, owner_q, owner_d, win;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [AWIDTH-1:0]   paddr_q, paddr_d;
   logic [DWIDTH-1:0]   pwdata_q, pwdata_d, rsp_rdata_q, rsp_rdata_d;
   logic                pwrite_q, pwrite_d, rsp_err_q, rsp_err_d;
   logic [NREQ-1:0]     req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d;
   logic                any_req, timeout_hit;
   assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));
   // round-robin pick: scan downward so the requester closest after last wins
   always_comb begin
      win = last_q;
      any_req = 1'b0;
      for (int k = NREQ; k >= 1; k--) begin
         if (req_valid_i[LW'((int'(last_q) + k) % NREQ)]) begin
            win = LW'((int'(last_q) + k) % NREQ);
            any_req = 1'b1;
         end
      end
   end
   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end
   // FSM next state: SETUP always lasts one cycle, ACCESS ends on pready or timeout
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = any_req ? SETUP : IDLE;
         SETUP:   state_d = ACCESS;
         ACCESS:  state_d = (pready_i || timeout_hit) ? IDLE : ACCESS;
         default: state_d = IDLE;
      endcase
   end
   // datapath next values: latch the winner on grant, build the response on completion
   always_comb begin
      last_d      = last_q;
      owner_d     = owner_q;
      cnt_d       = cnt_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      pwrite_d    = pwrite_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      req_ready_d = '0;
      rsp_valid_d = '0;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               owner_d          = win;
               last_d           = win;
               paddr_d          = req_addr_i[int'(win)*AWIDTH +: AWIDTH];
               pwdata_d         = req_wdata_i[int'(win)*DWIDTH +: DWIDTH];
               pwrite_d         = req_write_i[win];
               req_ready_d[win] = 1'b1;
            end
         end
         SETUP: cnt_d = '0;
         ACCESS: begin
            if (pready_i) begin
               rsp_valid_d[owner_q] = 1'b1;
               rsp_err_d            = pslverr_i;
               rsp_rdata_d          = pwrite_q ? '0 : prdata_i;
            end else if (timeout_hit) begin
               rsp_valid_d[owner_q] = 1'b1;
               rsp_err_d            = 1'b1;
               rsp_rdata_d          = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: ;
      endcase
   end
   // datapath registers; last resets to NREQ-1 so requester 0 goes first
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q      <= LW'(NREQ - 1);
         owner_q     <= '0;
         cnt_q       <= '0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         pwrite_q    <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         req_ready_q <= '0;
         rsp_valid_q <= '0;
      end else begin
         last_q      <= last_d;
         owner_q     <= owner_d;
         cnt_q       <= cnt_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         pwrite_q    <= pwrite_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end
   // outputs decoded from state or taken straight from registers
   always_comb begin
      psel_o      = state_q != IDLE;
      penable_o   = state_q == ACCESS;
      busy_o      = state_q != IDLE;
      pwrite_o    = pwrite_q;
      paddr_o     = paddr_q;
      pwdata_o    = pwdata_q;
      req_ready_o = req_ready_q;
      rsp_valid_o = rsp_valid_q;
      rsp_rdata_o = rsp_rdata_q;
      rsp_err_o   = rsp_err_q;
   end
endmodule

// File: tb/tb_apb_master_arb.sv
// tb_apb_master_arb: directed checks of arbitration, APB phasing, wait states, errors, timeout and reset
module tb_apb_master_arb;
   localparam int DW = 32;
   localparam int AW = 10;
   localparam int NR = 4;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [NR-1:0] req_valid = '0, req_write = '0, req_ready, rsp_valid;
   logic [NR*AW-1:0] req_addr = '0;
   logic [NR*DW-1:0] req_wdata = '0;
   logic [DW-1:0] rsp_rdata, pwdata, prdata = '0;
   logic [AW-1:0] paddr;
   logic rsp_err, busy, psel, penable, pwrite;
   logic pready = 1'b1, pslverr = 1'b0;
   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   apb_master_arb #(.DWIDTH(DW), .AWIDTH(AW), .NREQ(NR), .TIMEOUT(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid_i(req_valid), .req_write_i(req_write), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
      .req_ready_o(req_ready), .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
      .busy_o(busy), .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite),
      .paddr_o(paddr), .pwdata_o(pwdata), .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_write[i] = w;
      req_addr[i*AW +: AW] = a;
      req_wdata[i*DW +: DW] = d;
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if ({psel, penable, busy} !== 3'b000 || req_ready !== 4'h0 || rsp_valid !== 4'h0) begin
         failures++;
         $display("FAIL reset_assert: psel=%b penable=%b busy=%b req_ready=%b rsp_valid=%b, expected all 0", psel, penable, busy, req_ready, rsp_valid);
      end
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cyc();
         checks++;
         if ({psel, penable, busy, rsp_err} !== 4'b0000 || req_ready !== 4'h0 || rsp_valid !== 4'h0 || paddr !== 10'h0 || pwdata !== 32'h0 || rsp_rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_idle cycle %0d: psel=%b penable=%b busy=%b req_ready=%b rsp_valid=%b paddr=%h pwdata=%h, expected all 0", i, psel, penable, busy, req_ready, rsp_valid, paddr, pwdata);
         end
      end
   endtask

   task automatic test_write();
      set_req(0, 1'b1, 10'h004, 32'hDEADBEEF);
      prdata = 32'hAAAA5555;
      pready = 1'b1;
      req_valid = 4'b0001;
      cyc();
      checks++;
      if ({psel, penable, pwrite, busy} !== 4'b1011 || req_ready !== 4'b0001 || paddr !== 10'h004 || pwdata !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL write_setup: psel=%b penable=%b pwrite=%b busy=%b req_ready=%b paddr=%h pwdata=%h, expected 1,0,1,1,0001,004,deadbeef", psel, penable, pwrite, busy, req_ready, paddr, pwdata);
      end
      req_valid = 4'b0000;
      cyc();
      checks++;
      if ({psel, penable} !== 2'b11 || req_ready !== 4'h0 || rsp_valid !== 4'h0 || paddr !== 10'h004 || pwdata !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL write_access: psel=%b penable=%b req_ready=%b rsp_valid=%b paddr=%h pwdata=%h, expected 1,1,0000,0000,004,deadbeef", psel, penable, req_ready, rsp_valid, paddr, pwdata);
      end
      cyc();
      checks++;
      if ({psel, penable, busy} !== 3'b000 || rsp_valid !== 4'b0001 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
         failures++;
         $display("FAIL write_rsp: psel=%b penable=%b busy=%b rsp_valid=%b rsp_err=%b rsp_rdata=%h, expected 0,0,0,0001,0,0", psel, penable, busy, rsp_valid, rsp_err, rsp_rdata);
      end
      cyc();
      checks++;
      if (rsp_valid !== 4'h0 || psel !== 1'b0 || req_ready !== 4'h0) begin
         failures++;
         $display("FAIL write_after: rsp_valid=%b psel=%b req_ready=%b, expected 0000,0,0000", rsp_valid, psel, req_ready);
      end
   endtask

   task automatic test_read_wait();
      set_req(2, 1'b0, 10'h010, 32'h0);
      pready = 1'b0;
      prdata = 32'hFFFF0000;
      req_valid = 4'b0100;
      cyc();
      checks++;
      if ({psel, penable, pwrite} !== 3'b100 || req_ready !== 4'b0100 || paddr !== 10'h010) begin
         failures++;
         $display("FAIL read_setup: psel=%b penable=%b pwrite=%b req_ready=%b paddr=%h, expected 1,0,0,0100,010", psel, penable, pwrite, req_ready, paddr);
      end
      req_valid = 4'b0000;
      for (int i = 0; i < 3; i++) begin
         cyc();
         checks++;
         if ({psel, penable} !== 2'b11 || rsp_valid !== 4'h0) begin
            failures++;
            $display("FAIL read_wait cycle %0d: psel=%b penable=%b rsp_valid=%b, expected 1,1,0000", i, psel, penable, rsp_valid);
         end
      end
      pready = 1'b1;
      prdata = 32'h12345678;
      cyc();
      checks++;
      if ({psel, penable} !== 2'b00 || rsp_valid !== 4'b0100 || rsp_err !== 1'b0 || rsp_rdata !== 32'h12345678) begin
         failures++;
         $display("FAIL read_rsp: psel=%b penable=%b rsp_valid=%b rsp_err=%b rsp_rdata=%h, expected 0,0,0100,0,12345678", psel, penable, rsp_valid, rsp_err, rsp_rdata);
      end
   endtask

   task automatic test_timeout();
      set_req(1, 1'b0, 10'h0C8, 32'h0);
      set_req(3, 1'b1, 10'h03C, 32'hCAFEF00D);
      pready = 1'b0;
      prdata = 32'h5A5A5A5A;
      req_valid = 4'b0010;
      cyc();
      checks++;
      if (req_ready !== 4'b0010 || paddr !== 10'h0C8) begin
         failures++;
         $display("FAIL timeout_grant: req_ready=%b paddr=%h, expected 0010,0c8", req_ready, paddr);
      end
      req_valid = 4'b1000;
      for (int i = 0; i < 8; i++) begin
         cyc();
         checks++;
         if ({psel, penable} !== 2'b11 || rsp_valid !== 4'h0 || req_ready !== 4'h0) begin
            failures++;
            $display("FAIL timeout_access cycle %0d: psel=%b penable=%b rsp_valid=%b req_ready=%b, expected 1,1,0000,0000", i, psel, penable, rsp_valid, req_ready);
         end
      end
      cyc();
      checks++;
      if ({psel, penable} !== 2'b00 || rsp_valid !== 4'b0010 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin
         failures++;
         $display("FAIL timeout_abort: psel=%b penable=%b rsp_valid=%b rsp_err=%b rsp_rdata=%h, expected 0,0,0010,1,0", psel, penable, rsp_valid, rsp_err, rsp_rdata);
      end
      pready = 1'b1;
      cyc();
      checks++;
      if ({psel, penable} !== 2'b10 || req_ready !== 4'b1000 || paddr !== 10'h03C || pwdata !== 32'hCAFEF00D) begin
         failures++;
         $display("FAIL timeout_next_grant: psel=%b penable=%b req_ready=%b paddr=%h pwdata=%h, expected 1,0,1000,03c,cafef00d", psel, penable, req_ready, paddr, pwdata);
      end
      req_valid = 4'b0000;
      cyc();
      cyc();
      checks++;
      if (rsp_valid !== 4'b1000 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
         failures++;
         $display("FAIL timeout_next_rsp: rsp_valid=%b rsp_err=%b rsp_rdata=%h, expected 1000,0,0", rsp_valid, rsp_err, rsp_rdata);
      end
   endtask

   task automatic test_back_to_back();
      logic [NR-1:0] exp;
      logic [AW-1:0] ea;
      for (int i = 0; i < NR; i++) set_req(i, 1'b1, AW'(10'h100 + 4 * i), 32'h11110000 + DW'(i));
      pready = 1'b1;
      req_valid = 4'b1111;
      for (int k = 0; k < 18; k++) begin
         cyc();
         exp = 4'b0001 << ((k / 3) % 4);
         ea = AW'(10'h100 + 4 * ((k / 3) % 4));
         checks++;
         if (k % 3 == 0) begin
            if ({psel, penable} !== 2'b10 || req_ready !== exp || paddr !== ea) begin
               failures++;
               $display("FAIL rr_grant step %0d: psel=%b penable=%b req_ready=%b paddr=%h, expected 1,0,%b,%h", k, psel, penable, req_ready, paddr, exp, ea);
            end
         end else if (k % 3 == 1) begin
            if ({psel, penable} !== 2'b11 || req_ready !== 4'h0 || rsp_valid !== 4'h0) begin
               failures++;
               $display("FAIL rr_access step %0d: psel=%b penable=%b req_ready=%b rsp_valid=%b, expected 1,1,0000,0000", k, psel, penable, req_ready, rsp_valid);
            end
         end else begin
            if ({psel, busy} !== 2'b00 || rsp_valid !== exp || rsp_err !== 1'b0) begin
               failures++;
               $display("FAIL rr_rsp step %0d: psel=%b busy=%b rsp_valid=%b rsp_err=%b, expected 0,0,%b,0", k, psel, busy, rsp_valid, rsp_err, exp);
            end
         end
      end
      req_valid = 4'b0000;
      cyc();
      checks++;
      if (psel !== 1'b0 || req_ready !== 4'h0 || rsp_valid !== 4'h0) begin
         failures++;
         $display("FAIL rr_drain: psel=%b req_ready=%b rsp_valid=%b, expected 0,0000,0000", psel, req_ready, rsp_valid);
      end
   endtask

   task automatic test_pslverr();
      set_req(2, 1'b1, 10'h020, 32'h0BADF00D);
      pready = 1'b1;
      pslverr = 1'b1;
      req_valid = 4'b0100;
      cyc();
      checks++;
      if (req_ready !== 4'b0100 || paddr !== 10'h020) begin
         failures++;
         $display("FAIL slverr_grant: req_ready=%b paddr=%h, expected 0100,020", req_ready, paddr);
      end
      req_valid = 4'b0000;
      cyc();
      cyc();
      checks++;
      if (rsp_valid !== 4'b0100 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin
         failures++;
         $display("FAIL slverr_rsp: rsp_valid=%b rsp_err=%b rsp_rdata=%h, expected 0100,1,0", rsp_valid, rsp_err, rsp_rdata);
      end
      pslverr = 1'b0;
   endtask

   task automatic test_reset_mid();
      set_req(0, 1'b0, 10'h2A0, 32'h0);
      pready = 1'b0;
      req_valid = 4'b0001;
      cyc();
      checks++;
      if (req_ready !== 4'b0001) begin
         failures++;
         $display("FAIL rstmid_grant: req_ready=%b, expected 0001", req_ready);
      end
      req_valid = 4'b0000;
      cyc();
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({psel, penable, busy} !== 3'b000 || paddr !== 10'h0 || rsp_valid !== 4'h0 || req_ready !== 4'h0) begin
         failures++;
         $display("FAIL rstmid_async: psel=%b penable=%b busy=%b paddr=%h rsp_valid=%b req_ready=%b, expected all 0", psel, penable, busy, paddr, rsp_valid, req_ready);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      pready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         cyc();
         checks++;
         if (rsp_valid !== 4'h0 || psel !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_norsp cycle %0d: rsp_valid=%b psel=%b, expected 0000,0", i, rsp_valid, psel);
         end
      end
      set_req(3, 1'b1, 10'h3F0, 32'h77);
      set_req(0, 1'b1, 10'h001, 32'h66);
      req_valid = 4'b1001;
      cyc();
      checks++;
      if (req_ready !== 4'b0001 || paddr !== 10'h001) begin
         failures++;
         $display("FAIL rstmid_priority: req_ready=%b paddr=%h, expected 0001,001", req_ready, paddr);
      end
      req_valid = 4'b0000;
      cyc();
      cyc();
      checks++;
      if (rsp_valid !== 4'b0001 || rsp_err !== 1'b0) begin
         failures++;
         $display("FAIL rstmid_rsp: rsp_valid=%b rsp_err=%b, expected 0001,0", rsp_valid, rsp_err);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_write();
      test_read_wait();
      test_timeout();
      test_back_to_back();
      test_pslverr();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
